// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite/HUD ROM among N_REQ pixel fetchers.
// A tag pipeline matched to the ROM latency routes each returned word back to the requester that issued it.
module sprite_rom_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      busy
);

    localparam int          PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          DEPTH = ROM_LAT + 1;
    localparam int unsigned NR    = N_REQ;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic             win_vld;
    logic [N_REQ-1:0] eligible;
    int unsigned      cand;

    logic [DEPTH-1:0] tag_v;
    logic [PTR_W-1:0] tag_id [DEPTH];

    // Reset also blocks arbitration so gnt reads 0 for the whole reset cycle.
    assign eligible = req & {N_REQ{~hold & ~rst}};

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        gnt     = '0;
        cand    = 0;
        for (int unsigned j = 0; j < NR; j++) begin
            cand = (32'(ptr) + j) % NR;
            if (!win_vld && eligible[cand]) begin
                win_vld   = 1'b1;
                win_idx   = PTR_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
        end else begin
            rom_en <= win_vld;
            if (win_vld) begin
                ptr      <= (32'(win_idx) == NR - 1) ? '0 : win_idx + 1'b1;
                rom_addr <= addr[32'(win_idx)*ADDR_W +: ADDR_W];
            end
        end
    end

    // Entry 0 runs in parallel with rom_en; the last entry lines up with valid rom_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
        end else begin
            tag_v <= {tag_v[DEPTH-2:0], win_vld};
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= win_idx;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            if (tag_v[DEPTH-1]) begin
                rvalid[tag_id[DEPTH-1]] <= 1'b1;
                rdata                   <= rom_q;
            end
        end
    end

    assign busy = (|tag_v) | rom_en;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: ROM_LAT=1 and ROM_LAT=3 instances share stimulus and are
// checked every cycle against a grant-history model, plus directed literal checks.
module tb_sprite_rom_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst, hold;
    logic [2:0]      req;
    logic [3*AW-1:0] addr;

    logic [2:0]    gnt1, gnt3, rv1, rv3;
    logic [DW-1:0] rd1, rd3, q1, q3;
    logic          en1, en3, bz1, bz3;
    logic [AW-1:0] ra1, ra3;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .hold(hold), .req(req), .addr(addr), .gnt(gnt1),
        .rvalid(rv1), .rdata(rd1), .rom_en(en1), .rom_addr(ra1), .rom_q(q1), .busy(bz1));

    sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .hold(hold), .req(req), .addr(addr), .gnt(gnt3),
        .rvalid(rv3), .rdata(rd3), .rom_en(en3), .rom_addr(ra3), .rom_q(q3), .busy(bz3));

    // ROM contents q = addr[7:0]; a filler value when not enabled exposes misaligned capture.
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [3];
    always @(posedge clk) begin
        p1    <= en1 ? ra1[7:0] : 8'h5A;
        p3[0] <= en3 ? ra3[7:0] : 8'h5A;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign q1 = p1;
    assign q3 = p3[2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;
    bit started = 1'b0;

    // Model: ptr plus a history of grants; hist index k = grant made k+1 cycles ago.
    int            m_ptr = 0;
    bit            hv  [6];
    int            hid [6];
    logic [AW-1:0] ha  [6];
    logic [DW-1:0] m_rd1 = '0;
    logic [DW-1:0] m_rd3 = '0;
    logic [AW-1:0] m_ra = '0;
    logic [2:0]    m_last_gnt = '0;

    int            gnt_log [$];
    logic [DW-1:0] rd1_log [$];
    int            rv0_cnt = 0;

    function automatic logic [AW-1:0] addr_of(input int i);
        return addr[i*AW +: AW];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 6; k++) begin
            hv[k] = 1'b0; hid[k] = 0; ha[k] = '0;
        end
    end

    logic [2:0] eg, e_gnt, e_rv1, e_rv3;
    int         w;

    always @(negedge clk) begin
        if (started) begin
            eg = (rst || hold) ? 3'b000 : req;
            w  = -1;
            for (int j = 0; j < 3; j++)
                if (w < 0 && eg[(m_ptr + j) % 3]) w = (m_ptr + j) % 3;
            e_gnt = (w < 0) ? 3'b000 : (3'b001 << w);

            e_rv1 = hv[2] ? (3'b001 << hid[2]) : 3'b000;
            if (hv[2]) m_rd1 = ha[2][7:0];
            e_rv3 = hv[4] ? (3'b001 << hid[4]) : 3'b000;
            if (hv[4]) m_rd3 = ha[4][7:0];

            chk("gnt_l1", 32'(gnt1), 32'(e_gnt));
            chk("gnt_l3", 32'(gnt3), 32'(e_gnt));
            chk("rom_en_l1", 32'(en1), 32'(hv[0]));
            chk("rom_en_l3", 32'(en3), 32'(hv[0]));
            chk("rom_addr_l1", 32'(ra1), 32'(m_ra));
            chk("rom_addr_l3", 32'(ra3), 32'(m_ra));
            chk("rvalid_l1", 32'(rv1), 32'(e_rv1));
            chk("rvalid_l3", 32'(rv3), 32'(e_rv3));
            chk("rdata_l1", 32'(rd1), 32'(m_rd1));
            chk("rdata_l3", 32'(rd3), 32'(m_rd3));
            chk("busy_l1", 32'(bz1), 32'(hv[0] | hv[1]));
            chk("busy_l3", 32'(bz3), 32'(hv[0] | hv[1] | hv[2] | hv[3]));

            for (int i = 0; i < 3; i++) if (gnt1[i]) gnt_log.push_back(i);
            if (rv1[1]) rd1_log.push_back(rd1);
            if (rv1[0]) rv0_cnt++;

            for (int k = 5; k > 0; k--) begin
                hv[k] = hv[k-1]; hid[k] = hid[k-1]; ha[k] = ha[k-1];
            end
            hv[0]  = (w >= 0);
            hid[0] = (w >= 0) ? w : 0;
            ha[0]  = (w >= 0) ? addr_of(w) : '0;
            if (w >= 0) begin
                m_ptr = (w + 1) % 3;
                m_ra  = addr_of(w);
            end
            m_last_gnt = e_gnt;
            if (rst) begin
                for (int k = 0; k < 6; k++) hv[k] = 1'b0;
                m_ptr = 0; m_ra = '0; m_rd1 = '0; m_rd3 = '0;
            end
            cyc_n++;
        end
    end

    task automatic drive(input logic r, input logic h, input logic [2:0] rq,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rst  = r;
        hold = h;
        req  = rq;
        addr = {a2, a1, a0};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'b000, '0, '0, '0);
    endtask

    task automatic chk_order(input string name, input int exp_q [$]);
        chk({name, "_count"}, 32'(gnt_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < gnt_log.size() && i < exp_q.size(); i++)
            chk(name, 32'(gnt_log[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int exp_q [$];
        logic [2:0]    nr;
        logic [AW-1:0] na [3];
        logic          r, h;

        rst = 1'b1; hold = 1'b0; req = '0; addr = '0;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        drive(1'b1, 1'b0, 3'b000, '0, '0, '0);

        // Single requester, back-to-back grants with a new address each time
        gnt_log.delete(); rd1_log.delete();
        drive(1'b0, 1'b0, 3'b010, '0, 15'h0010, '0);
        drive(1'b0, 1'b0, 3'b010, '0, 15'h0011, '0);
        drive(1'b0, 1'b0, 3'b010, '0, 15'h0012, '0);
        idle(8);
        exp_q = '{1, 1, 1};
        chk_order("s1_order", exp_q);
        chk("s1_rdata_count", 32'(rd1_log.size()), 32'd3);
        for (int i = 0; i < rd1_log.size(); i++)
            chk("s1_rdata", 32'(rd1_log[i]), 32'h10 + 32'(i));

        // All three requesting from reset
        drive(1'b1, 1'b0, 3'b000, '0, '0, '0);
        gnt_log.delete();
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 3'b111, 15'h0100, 15'h0201, 15'h0302);
        idle(8);
        exp_q = '{0, 1, 2, 0, 1, 2};
        chk_order("s2_order", exp_q);

        // Contention after an idle gap: ptr wraps past 2
        gnt_log.delete();
        drive(1'b0, 1'b0, 3'b100, '0, '0, 15'h0055);
        drive(1'b0, 1'b0, 3'b101, 15'h00A1, '0, 15'h00A2);
        drive(1'b0, 1'b0, 3'b101, 15'h00A1, '0, 15'h00A3);
        idle(6);
        exp_q = '{2, 0, 2};
        chk_order("s3_order", exp_q);

        // hold with two reads in flight
        gnt_log.delete(); rv0_cnt = 0;
        drive(1'b0, 1'b0, 3'b001, 15'h0040, '0, '0);
        drive(1'b0, 1'b0, 3'b001, 15'h0041, '0, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 3'b001, 15'h0042, '0, '0);
        drive(1'b0, 1'b0, 3'b001, 15'h0042, '0, '0);
        idle(8);
        exp_q = '{0, 0, 0};
        chk_order("s4_order", exp_q);
        chk("s4_rvalid0_count", 32'(rv0_cnt), 32'd3);

        // Reset with reads in flight; first grant afterwards goes to lowest index
        gnt_log.delete();
        drive(1'b0, 1'b0, 3'b011, 15'h0061, 15'h0062, '0);
        drive(1'b0, 1'b0, 3'b011, 15'h0063, 15'h0064, '0);
        drive(1'b1, 1'b0, 3'b111, 15'h0063, 15'h0064, 15'h0065);
        drive(1'b0, 1'b0, 3'b110, '0, 15'h0066, 15'h0067);
        idle(8);
        exp_q = '{1, 0, 1};
        chk_order("s5_order", exp_q);

        // Random traffic honouring the hold-until-granted contract
        for (int c = 0; c < 250; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (req[i] && !m_last_gnt[i]) begin
                    nr[i] = 1'b1;
                    na[i] = addr_of(i);
                end else begin
                    nr[i] = ($urandom_range(0, 9) < 6);
                    na[i] = AW'($urandom);
                end
            end
            h = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 59) == 0);
            drive(r, h, nr, na[0], na[1], na[2]);
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
